ula_video: RTL

//  ZX Spectrum video generator: frame/line counters, display memory fetch, pixel/attribute

---
 rtl/ula_pkg.sv | 32 +++
 rtl/ula_video_if.sv | 7 +
 rtl/ula_palette.sv | 13 +
 rtl/ula_video.sv | 83 ++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: ULA video timing constants and colour type.
// ZX128_TIMING_EN selects 128K line/frame lengths; the default build uses 48K timing.
package ula_pkg;
    localparam int RGBW = 9;
`ifdef ZX128_TIMING_EN
    localparam logic [8:0] HMAX = 9'd456;
    localparam logic [8:0] VMAX = 9'd311;
`else
    localparam logic [8:0] HMAX = 9'd448;
    localparam logic [8:0] VMAX = 9'd312;
`endif
    localparam logic [8:0] H_ACT       = 9'd256;
    localparam logic [8:0] V_ACT       = 9'd192;
    localparam logic [8:0] HB_BEG      = 9'd320;
    localparam logic [8:0] HB_END      = 9'd416;
    localparam logic [8:0] HS_BEG      = 9'd344;
    localparam logic [8:0] HS_END      = 9'd376;
    localparam logic [8:0] VB_BEG      = 9'd248;
    localparam logic [8:0] VB_END      = 9'd256;
    localparam logic [8:0] VS_BEG      = 9'd248;
    localparam logic [8:0] VS_END      = 9'd252;
    localparam logic [8:0] IRQ_LINE    = 9'd248;
    localparam logic [8:0] IRQ_LEN     = 9'd64;
    localparam logic [8:0] FETCH_AHEAD = 9'd8;
    localparam logic [12:0] ATTR_BASE  = 13'h1800;

    typedef struct packed {
        logic g;
        logic r;
        logic b;
    } colour_t;
endpackage

// File: rtl/ula_video_if.sv
// ula_video_if: display memory port; the ULA presents va, memory returns vd one ce later.
interface ula_video_if;
    logic [12:0] va;
    logic [7:0]  vd;
    modport master (output va, input vd);
    modport slave  (input va, output vd);
endinterface

// File: rtl/ula_palette.sv
// ula_palette: maps a {G,R,B} colour plus bright flag to 9-bit {R,G,B}.
module ula_palette
    import ula_pkg::*;
(
    input  colour_t         i_col,
    input  logic            i_bright,
    output logic [RGBW-1:0] o_rgb
);
    logic [2:0] w_lvl;

    assign w_lvl = {2'b11, i_bright};
    assign o_rgb = {i_col.r ? w_lvl : 3'd0, i_col.g ? w_lvl : 3'd0, i_col.b ? w_lvl : 3'd0};
endmodule

// File: rtl/ula_video.sv
// ula_video: ZX Spectrum ULA video - counters, screen fetch, pixel shifter, flash and border.
// Build with ZX128_TIMING_EN for 128K line/frame timing.
module ula_video
    import ula_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_ce,
    input  logic [2:0]      i_border,
    ula_video_if.master     mem,
    output logic            o_hs,
    output logic            o_vs,
    output logic [RGBW-1:0] o_rgb,
    output logic            o_irq_n
);
    logic [8:0]      r_hc, r_vc;
    logic [12:0]     r_va;
    logic [7:0]      r_bmp_lat, r_atr_lat, r_shift, r_attr;
    logic [4:0]      r_flash;
    logic            r_hs, r_vs, r_irq_n;
    logic [RGBW-1:0] r_rgb;
    logic            w_hwrap, w_pre, w_fetch, w_act, w_blank, w_bit, w_bright;
    logic [8:0]      w_vnext, w_fc, w_vf;
    colour_t         w_col;
    logic [RGBW-1:0] w_rgb;

    assign w_hwrap = r_hc == HMAX - 9'd1;
    assign w_vnext = (r_vc == VMAX - 9'd1) ? 9'd0 : r_vc + 9'd1;
    // The first group of a line is fetched during the last 8 ce of the previous line.
    assign w_pre   = r_hc >= HMAX - FETCH_AHEAD;
    assign w_fc    = r_hc + FETCH_AHEAD - (w_pre ? HMAX : 9'd0);
    assign w_vf    = w_pre ? w_vnext : r_vc;
    assign w_fetch = w_fc < H_ACT && w_vf < V_ACT;

    assign w_act    = r_hc < H_ACT && r_vc < V_ACT;
    assign w_blank  = (r_hc >= HB_BEG && r_hc < HB_END) || (r_vc >= VB_BEG && r_vc < VB_END);
    // Swapping ink and paper is the same as inverting the pixel bit.
    assign w_bit    = r_shift[7] ^ (r_attr[7] & r_flash[4]);
    assign w_col    = w_act ? colour_t'(w_bit ? r_attr[2:0] : r_attr[5:3]) : colour_t'(i_border);
    assign w_bright = w_act & r_attr[6];

    ula_palette u_pal (
        .i_col    (w_col),
        .i_bright (w_bright),
        .o_rgb    (w_rgb)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_hc      <= '0;
            r_vc      <= '0;
            r_va      <= '0;
            r_bmp_lat <= '0;
            r_atr_lat <= '0;
            r_shift   <= '0;
            r_attr    <= '0;
            r_flash   <= '0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_irq_n   <= 1'b1;
            r_rgb     <= '0;
        end else if (i_ce) begin
            r_hc <= w_hwrap ? 9'd0 : r_hc + 9'd1;
            if (w_hwrap) r_vc <= w_vnext;
            if (w_hwrap && w_vnext == VB_BEG) r_flash <= r_flash + 5'd1;
            if (w_fetch && r_hc[2:0] == 3'd2) r_va <= {w_vf[7:6], w_vf[2:0], w_vf[5:3], w_fc[7:3]};
            if (w_fetch && r_hc[2:0] == 3'd3) r_bmp_lat <= mem.vd;
            if (w_fetch && r_hc[2:0] == 3'd4) r_va <= ATTR_BASE + {3'd0, w_vf[7:3], w_fc[7:3]};
            if (w_fetch && r_hc[2:0] == 3'd5) r_atr_lat <= mem.vd;
            r_shift <= (r_hc[2:0] == 3'd7) ? r_bmp_lat : {r_shift[6:0], 1'b0};
            if (r_hc[2:0] == 3'd7) r_attr <= r_atr_lat;
            r_hs    <= r_hc >= HS_BEG && r_hc < HS_END;
            r_vs    <= r_vc >= VS_BEG && r_vc < VS_END;
            r_irq_n <= !(r_vc == IRQ_LINE && r_hc < IRQ_LEN);
            r_rgb   <= w_blank ? '0 : w_rgb;
        end

    assign mem.va  = r_va;
    assign o_hs    = r_hs;
    assign o_vs    = r_vs;
    assign o_rgb   = r_rgb;
    assign o_irq_n = r_irq_n;
endmodule
